// File: rtl/fp_ci_pkg.sv
// Shared opcodes, FSM states and IEEE-754 single constants for the FP custom-instruction responder.
package fp_ci_pkg;

    typedef enum logic [2:0] {
        FP_OP_FIXSI   = 3'b001,
        FP_OP_FLOATIS = 3'b010,
        FP_OP_FMULS   = 3'b100
    } fp_op_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } fp_state_e;

    localparam int unsigned EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] PINF     = 32'h7F80_0000;
    localparam logic [31:0] NINF     = 32'hFF80_0000;

    // Leading-zero count; the all-zero input is special-cased by callers.
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt   = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack into IEEE-754 single; saturates to inf or flushes to signed zero.
// Flag outputs exist only when FP_CI_STATUS_EN is defined.
module fp_round_pack
    import fp_ci_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,   // biased exponent of the leading one
    input  logic [26:0]       mant_i,  // {1.fraction[23:0], guard, round, sticky}
    output logic [31:0]       packed_o
`ifdef FP_CI_STATUS_EN
    ,
    output logic              ovf_o,
    output logic              unf_o,
    output logic              inexact_o
`endif
);

    logic              guard;
    logic              rs;
    logic              rnd_up;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic signed [9:0] exp_adj;
    logic              ovf;
    logic              unf;

    always_comb begin
        guard   = mant_i[2];
        rs      = mant_i[1] | mant_i[0];
        rnd_up  = guard & (rs | mant_i[3]);
        sum     = {1'b0, mant_i[26:3]} + {24'b0, rnd_up};
        // A carry out of the mantissa means 1.111..1 rounded up to 10.000..0
        frac    = sum[24] ? sum[23:1] : sum[22:0];
        exp_adj = exp_i + $signed({9'b0, sum[24]});
        ovf     = exp_adj >= 10'sd255;
        unf     = exp_adj <= 10'sd0;
        if (ovf)      packed_o = {sign_i, PINF[30:0]};
        else if (unf) packed_o = {sign_i, 31'b0};
        else          packed_o = {sign_i, exp_adj[7:0], frac};
    end

`ifdef FP_CI_STATUS_EN
    assign ovf_o     = ovf;
    assign unf_o     = unf;
    assign inexact_o = guard | rs | ovf | unf;
`endif

endmodule

// File: rtl/fp_ci_responder.sv
// Multicycle FP custom-instruction responder: FLOATIS, FMULS, FIXSI with LATENCY-cycle done pulse.
// Define FP_CI_STATUS_EN to add the 4-bit status port {invalid,overflow,underflow,inexact}.
module fp_ci_responder
    import fp_ci_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [2:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
`ifdef FP_CI_STATUS_EN
    ,
    output logic [3:0]  status
`endif
);

    localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

    fp_state_e   state_q;
    logic [3:0]  cnt_q;

    logic [31:0] fl_abs, fl_norm;
    logic [4:0]  fl_lz;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, mul_sign;
    logic [47:0] prod;
    logic [7:0]  fx_e, fx_sh;
    logic [31:0] fx_mag;
    logic        rp_sign;
    logic signed [9:0] rp_exp;
    logic [26:0] rp_mant;
    logic [31:0] rp_packed;
    logic [31:0] res_c;
`ifdef FP_CI_STATUS_EN
    logic        rp_ovf, rp_unf, rp_inx;
    logic [62:0] fx_ext;
    logic [3:0]  flags_c;
`endif

    always_comb begin
        fl_abs  = dataa[31] ? (~dataa + 32'd1) : dataa;
        fl_lz   = lzc32(fl_abs);
        fl_norm = fl_abs << fl_lz;

        a_zero   = dataa[30:23] == 8'd0;
        b_zero   = datab[30:23] == 8'd0;
        a_inf    = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
        b_inf    = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'd0);
        a_nan    = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
        b_nan    = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0);
        mul_sign = dataa[31] ^ datab[31];
        prod     = 48'({1'b1, dataa[22:0]}) * 48'({1'b1, datab[22:0]});

        // {1.f, 8'b0} is the operand scaled to 2^31; shift down to the integer part
        fx_e   = dataa[30:23];
        fx_sh  = 8'd158 - fx_e;
        fx_mag = {1'b1, dataa[22:0], 8'b0} >> fx_sh;

        if (n == FP_OP_FMULS) begin
            rp_sign = mul_sign;
            rp_exp  = 10'(dataa[30:23]) + 10'(datab[30:23]) - 10'd127 + 10'(prod[47]);
            rp_mant = prod[47] ? {prod[47:24], prod[23], prod[22], |prod[21:0]}
                               : {prod[46:23], prod[22], prod[21], |prod[20:0]};
        end else begin
            rp_sign = dataa[31];
            rp_exp  = 10'd158 - 10'(fl_lz);
            rp_mant = {fl_norm[31:8], fl_norm[7], fl_norm[6], |fl_norm[5:0]};
        end
    end

    fp_round_pack u_round_pack (
        .sign_i    (rp_sign),
        .exp_i     (rp_exp),
        .mant_i    (rp_mant),
        .packed_o  (rp_packed)
`ifdef FP_CI_STATUS_EN
        ,
        .ovf_o     (rp_ovf),
        .unf_o     (rp_unf),
        .inexact_o (rp_inx)
`endif
    );

    always_comb begin
        res_c = '0;
`ifdef FP_CI_STATUS_EN
        flags_c = '0;
        fx_ext  = {1'b1, dataa[22:0], 39'b0} >> fx_sh;
`endif
        case (n)
            FP_OP_FLOATIS: begin
                if (dataa != 32'd0) begin
                    res_c = rp_packed;
`ifdef FP_CI_STATUS_EN
                    flags_c = {1'b0, rp_ovf, rp_unf, rp_inx};
`endif
                end
            end
            FP_OP_FMULS: begin
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    res_c = QNAN;
`ifdef FP_CI_STATUS_EN
                    flags_c = 4'b1000;
`endif
                end else if (a_inf || b_inf) begin
                    res_c = {mul_sign, PINF[30:0]};
                end else if (a_zero || b_zero) begin
                    res_c = {mul_sign, 31'b0};
                end else begin
                    res_c = rp_packed;
`ifdef FP_CI_STATUS_EN
                    flags_c = {1'b0, rp_ovf, rp_unf, rp_inx};
`endif
                end
            end
            FP_OP_FIXSI: begin
                if (a_nan) begin
`ifdef FP_CI_STATUS_EN
                    flags_c = 4'b1000;
`endif
                end else if (fx_e < 8'd127) begin
`ifdef FP_CI_STATUS_EN
                    flags_c = {3'b000, |dataa[30:0]};
`endif
                end else if (fx_e >= 8'd158) begin
                    // -2^31 is representable; everything else out here saturates
                    if (dataa == 32'hCF00_0000) begin
                        res_c = INT_MIN;
                    end else begin
                        res_c = dataa[31] ? INT_MIN : INT_MAX;
`ifdef FP_CI_STATUS_EN
                        flags_c = 4'b1000;
`endif
                    end
                end else begin
                    res_c = dataa[31] ? (~fx_mag + 32'd1) : fx_mag;
`ifdef FP_CI_STATUS_EN
                    flags_c = {3'b000, |fx_ext[30:0]};
`endif
                end
            end
            default: begin
`ifdef FP_CI_STATUS_EN
                flags_c = 4'b1000;
`endif
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
`ifdef FP_CI_STATUS_EN
            status  <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= WAIT;
                        cnt_q   <= LatM1;
                        result  <= res_c;
                        busy    <= 1'b1;
`ifdef FP_CI_STATUS_EN
                        status  <= flags_c;
`endif
                    end else begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_ci_responder.sv
// Directed plus randomized bench for fp_ci_responder at LATENCY 1 and 3 against an arithmetic model.
module tb_fp_ci_responder;

    localparam logic [2:0] OpFixsi   = 3'b001;
    localparam logic [2:0] OpFloatis = 3'b010;
    localparam logic [2:0] OpFmuls   = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, start1, done1, busy1;
    logic [2:0]  n1;
    logic [31:0] a1, b1, res1;
    logic        rst3, start3, done3, busy3;
    logic [2:0]  n3;
    logic [31:0] a3, b3, res3;

    int total = 0;
    int bad   = 0;

    fp_ci_responder #(.LATENCY(1)) u_dut1 (
        .CLK(clk), .RESET(rst1), .start(start1), .n(n1), .dataa(a1), .datab(b1),
        .result(res1), .done(done1), .busy(busy1)
    );

    fp_ci_responder #(.LATENCY(3)) u_dut3 (
        .CLK(clk), .RESET(rst3), .start(start3), .n(n3), .dataa(a3), .datab(b3),
        .result(res3), .done(done3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Value = mag * 2^scale, rounded to 24 significant bits, nearest-even.
    function automatic logic [31:0] ref_pack(input bit sgn, input longint unsigned mag,
                                             input int scale);
        int p, e, d;
        longint unsigned q, rem, half;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = p + scale;
        if (p > 23) begin
            d    = p - 23;
            q    = mag >> d;
            rem  = mag - (q << d);
            half = 64'd1 << (d - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end else begin
            q = mag << (23 - p);
        end
        e = e + 127;
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        if (e <= 0)   return {sgn, 31'd0};
        return {sgn, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] ref_floatis(input logic [31:0] a);
        longint sv;
        sv = longint'($signed(a));
        if (sv == 0) return 32'd0;
        return ref_pack(sv < 0, (sv < 0) ? -sv : sv, 0);
    endfunction

    function automatic logic [31:0] ref_fmuls(input logic [31:0] a, input logic [31:0] b);
        int ea, eb;
        bit s, za, zb, ia, ib, na, nb;
        longint unsigned ma, mb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = ea == 0;
        zb = eb == 0;
        ia = ea == 255 && a[22:0] == 0;
        ib = eb == 255 && b[22:0] == 0;
        na = ea == 255 && a[22:0] != 0;
        nb = eb == 255 && b[22:0] != 0;
        if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC0_0000;
        if (ia || ib) return {s, 8'hFF, 23'd0};
        if (za || zb) return {s, 31'd0};
        ma = 64'h80_0000 | 64'(a[22:0]);
        mb = 64'h80_0000 | 64'(b[22:0]);
        return ref_pack(s, ma * mb, ea + eb - 300);
    endfunction

    function automatic logic [31:0] ref_fixsi(input logic [31:0] a);
        int e;
        longint unsigned ma, mag;
        logic [31:0] m32;
        e = int'(a[30:23]);
        if (e == 255 && a[22:0] != 0) return 32'd0;
        if (e < 127) return 32'd0;
        if (e >= 158) begin
            if (a == 32'hCF00_0000) return 32'h8000_0000;
            return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        ma  = 64'h80_0000 | 64'(a[22:0]);
        mag = (e >= 150) ? (ma << (e - 150)) : (ma >> (150 - e));
        m32 = mag[31:0];
        return a[31] ? (~m32 + 32'd1) : m32;
    endfunction

    task automatic issue1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        n1 = op; a1 = a; b1 = b; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done1(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40 && cyc < 0; i++) begin
            @(posedge clk); #1;
            if (done1) cyc = i;
        end
    endtask

    task automatic wait_done3(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40 && cyc < 0; i++) begin
            @(posedge clk); #1;
            if (done3) cyc = i;
        end
    endtask

    task automatic op1(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_v);
        int cyc;
        issue1(op, a, b);
        check({tag, ".busy_done"}, 32'({busy1, done1}), 32'd2);
        wait_done1(cyc);
        check({tag, ".lat"}, 32'(cyc), 32'd1);
        check({tag, ".res"}, res1, exp_v);
        @(posedge clk); #1;
        check({tag, ".pulse"}, 32'({done1, busy1}), 32'd0);
    endtask

    initial begin
        int cyc, seen;
        logic [31:0] a, b;

        rst1 = 1'b1; start1 = 1'b0; n1 = '0; a1 = '0; b1 = '0;
        rst3 = 1'b1; start3 = 1'b0; n3 = '0; a3 = '0; b3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst1.result", res1, 32'd0);
        check("rst1.done_busy", 32'({done1, busy1}), 32'd0);
        check("rst3.result", res3, 32'd0);
        check("rst3.done_busy", 32'({done3, busy3}), 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        op1("floatis_1000", OpFloatis, 32'd1000, 32'd0, 32'h447A_0000);
        op1("floatis_zero", OpFloatis, 32'd0, 32'd0, 32'h0000_0000);
        op1("floatis_max", OpFloatis, 32'h7FFF_FFFF, 32'd0, 32'h4F00_0000);
        op1("floatis_min", OpFloatis, 32'h8000_0000, 32'd0, 32'hCF00_0000);
        op1("fmuls_half", OpFmuls, 32'h447A_0000, 32'h3F00_0000, 32'h43FA_0000);
        op1("fmuls_ovf", OpFmuls, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
        op1("fmuls_inf0", OpFmuls, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        op1("fmuls_infx", OpFmuls, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        op1("fmuls_unf", OpFmuls, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        op1("fixsi_neg", OpFixsi, 32'hC3FA_0000, 32'd0, 32'hFFFF_FE0C);
        op1("fixsi_frac", OpFixsi, 32'h3FF0_0000, 32'd0, 32'h0000_0001);
        op1("fixsi_sat", OpFixsi, 32'h4F00_0000, 32'd0, 32'h7FFF_FFFF);
        op1("fixsi_min", OpFixsi, 32'hCF00_0000, 32'd0, 32'h8000_0000);
        op1("fixsi_ninf", OpFixsi, 32'hFF80_0000, 32'd0, 32'h8000_0000);
        op1("fixsi_nan", OpFixsi, 32'h7FC0_0000, 32'd0, 32'h0000_0000);
        op1("fixsi_small", OpFixsi, 32'h3F7F_FFFF, 32'd0, 32'h0000_0000);
        op1("unknown_op", 3'b011, 32'h1234_5678, 32'd0, 32'h0000_0000);

        // Gain chain, each start issued in the done cycle of the previous op
        issue1(OpFloatis, -32'sd12345, 32'd0);
        wait_done1(cyc);
        check("chain1.lat", 32'(cyc), 32'd1);
        check("chain1.res", res1, 32'hC640_E400);
        issue1(OpFmuls, 32'hC640_E400, 32'h4000_0000);
        check("chain2.busy_done", 32'({busy1, done1}), 32'd2);
        wait_done1(cyc);
        check("chain2.lat", 32'(cyc), 32'd1);
        check("chain2.res", res1, 32'hC6C0_E400);
        issue1(OpFixsi, 32'hC6C0_E400, 32'd0);
        wait_done1(cyc);
        check("chain3.lat", 32'(cyc), 32'd1);
        check("chain3.res", res1, 32'hFFFF_9F8E);
        @(posedge clk); #1;
        check("chain.end", 32'({done1, busy1}), 32'd0);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            op1("rnd_floatis", OpFloatis, a, 32'd0, ref_floatis(a));
        end
        for (int i = 0; i < 16; i++) begin
            if (i < 10) begin
                a = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
                b = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
            end else begin
                a = $urandom;
                b = $urandom;
            end
            op1("rnd_fmuls", OpFmuls, a, b, ref_fmuls(a, b));
        end
        for (int i = 0; i < 16; i++) begin
            a = {1'($urandom), 8'($urandom_range(115, 165)), 23'($urandom)};
            op1("rnd_fixsi", OpFixsi, a, 32'd0, ref_fixsi(a));
        end

        // LATENCY=3: a start during WAIT must be dropped
        n3 = OpFmuls; a3 = 32'h447A_0000; b3 = 32'h3F00_0000; start3 = 1'b1;
        @(posedge clk); #1;
        check("lat3.busy_done", 32'({busy3, done3}), 32'd2);
        n3 = OpFloatis; a3 = 32'd7; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        check("lat3.early_done", 32'(done3), 32'd0);
        cyc = -1;
        for (int i = 2; i <= 40 && cyc < 0; i++) begin
            @(posedge clk); #1;
            if (done3) cyc = i;
        end
        check("lat3.lat", 32'(cyc), 32'd3);
        check("lat3.res", res3, 32'h43FA_0000);
        check("lat3.busy_at_done", 32'(busy3), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done3) seen++;
        end
        check("lat3.no_queue", 32'(seen), 32'd0);
        check("lat3.idle", 32'(busy3), 32'd0);
        check("lat3.hold", res3, 32'h43FA_0000);

        // Reset one cycle after accept aborts the op
        n3 = OpFmuls; a3 = 32'h447A_0000; b3 = 32'h4000_0000; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        check("abort.result", res3, 32'd0);
        check("abort.done_busy", 32'({done3, busy3}), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done3) seen++;
        end
        check("abort.no_done", 32'(seen), 32'd0);
        n3 = OpFixsi; a3 = 32'hC3FA_0000; b3 = 32'd0; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        wait_done3(cyc);
        check("after_abort.lat", 32'(cyc), 32'd3);
        check("after_abort.res", res3, 32'hFFFF_FE0C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
